// File: rtl/mem_req_tracker_pkg.sv
// mem_pkg: shared widths, entry state encoding and entry record for the
// memory request tracker.
package mem_pkg;
  localparam int ID_W = 4;
  localparam int DEPTH = 1 << ID_W;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNTRL_W = 16;
  localparam int Z_W = 4;
  typedef enum logic [1:0] {FREE, WAIT, PENDING, DONE} state_t;
  typedef struct packed {
    state_t state;
    logic rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNTRL_W-1:0] cntrl;
    logic [Z_W-1:0] z;
  } entry_t;
endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: one tracker entry; holds the request payload and walks
// FREE -> WAIT -> PENDING/DONE -> FREE.
module mem_req_slot import mem_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic              issue,
  input  logic              resp,
  input  logic              retire,
  input  entry_t            wr,
  input  logic [DATA_W-1:0] rdata,
  output entry_t            q
);
  // A response that lands in the issue cycle loses to the issue, as the entry is not yet PENDING
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (alloc) q <= wr;
    else if (issue) begin
      q.state <= q.rw ? DONE : PENDING;
      if (q.rw) q.data <= '0;
    end
    else if (resp && q.state == PENDING) begin
      q.state <= DONE;
      q.data <= rdata;
    end
    else if (retire) q.state <= FREE;
  end
endmodule

// File: rtl/mem_req_tracker.sv
// mem_req_tracker: allocates ids in program order, issues in order to memory,
// accepts out-of-order responses by id and retires in order to MEM/WB.
module mem_req_tracker import mem_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic               ex_rw,
  input  logic [ADDR_W-1:0]  ex_addr,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [CNTRL_W-1:0] ex_cntrl,
  input  logic [Z_W-1:0]     ex_z,
  output logic               stall_out,
  output logic               mem_valid,
  output logic               mem_rw,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  output logic [ID_W-1:0]    mem_id,
  input  logic               mem_stall,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic [ID_W-1:0]    mem_rid,
  input  logic               mem_ready,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic [CNTRL_W-1:0] wb_cntrl,
  output logic [Z_W-1:0]     wb_z,
  output logic               err_out
);
  logic [ID_W-1:0] alloc_ptr, issue_ptr, retire_ptr;
  logic [ID_W:0] count;
  entry_t entries [DEPTH];
  entry_t wr;
  logic alloc_fire, issue_fire, retire_fire;
  assign stall_out = count == (ID_W+1)'(DEPTH);
  assign alloc_fire = ex_valid && !stall_out;
  assign mem_valid = entries[issue_ptr].state == WAIT;
  assign mem_rw = entries[issue_ptr].rw;
  assign mem_addr = entries[issue_ptr].addr;
  assign mem_data = entries[issue_ptr].data;
  assign mem_id = issue_ptr;
  assign issue_fire = mem_valid && !mem_stall;
  assign retire_fire = entries[retire_ptr].state == DONE;
  assign wr = '{state: WAIT, rw: ex_rw, addr: ex_addr, data: ex_wdata, cntrl: ex_cntrl, z: ex_z};
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    mem_req_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .alloc  (alloc_fire && alloc_ptr == ID_W'(i)),
      .issue  (issue_fire && issue_ptr == ID_W'(i)),
      .resp   (mem_ready && mem_rid == ID_W'(i)),
      .retire (retire_fire && retire_ptr == ID_W'(i)),
      .wr     (wr),
      .rdata  (mem_rdata),
      .q      (entries[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      issue_ptr <= '0;
      retire_ptr <= '0;
      count <= '0;
      err_out <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_cntrl <= '0;
      wb_z <= '0;
    end else begin
      alloc_ptr <= alloc_ptr + ID_W'(alloc_fire);
      issue_ptr <= issue_ptr + ID_W'(issue_fire);
      retire_ptr <= retire_ptr + ID_W'(retire_fire);
      count <= count + (ID_W+1)'(alloc_fire) - (ID_W+1)'(retire_fire);
      err_out <= err_out | (mem_ready && entries[mem_rid].state != PENDING);
      wb_valid <= retire_fire;
      if (retire_fire) begin
        wb_addr <= entries[retire_ptr].addr;
        wb_data <= entries[retire_ptr].data;
        wb_cntrl <= entries[retire_ptr].cntrl;
        wb_z <= entries[retire_ptr].z;
      end
    end
  end
endmodule

// File: tb/tb_mem_req_tracker.sv
// tb_mem_req_tracker: vector table, directed corner sequences and random traffic
// checked against a queue-based program-order model.
module tb_mem_req_tracker;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ex_rw = 0, mem_stall = 0, mem_ready = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0, mem_rdata = 0;
  logic [15:0] ex_cntrl = 0;
  logic [3:0] ex_z = 0, mem_rid = 0;
  logic stall_out, mem_valid, mem_rw, wb_valid, err_out;
  logic [31:0] mem_addr, mem_data, wb_addr, wb_data;
  logic [3:0] mem_id, wb_z;
  logic [15:0] wb_cntrl;

  mem_req_tracker dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_cntrl(ex_cntrl), .ex_z(ex_z), .stall_out(stall_out),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_id(mem_id), .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
    .mem_ready(mem_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_cntrl(wb_cntrl), .wb_z(wb_z), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: program-order queue of outstanding requests
  typedef struct {
    logic [3:0] id;
    logic rw;
    logic [31:0] addr, data;
    logic [15:0] cntrl;
    logic [3:0] z;
    bit issued, done;
  } rec_t;
  rec_t q[$];
  int next_id;
  bit m_err, m_wbv;
  logic [31:0] m_wba, m_wbd;
  logic [15:0] m_wbc;
  logic [3:0] m_wbz;

  function automatic int first_unissued();
    foreach (q[k]) if (!q[k].issued) return k;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    next_id = 0; m_err = 0; m_wbv = 0;
    m_wba = 0; m_wbd = 0; m_wbc = 0; m_wbz = 0;
  endtask

  task automatic model_step();
    int iss;
    bit ret, full, hit;
    rec_t r;
    iss = first_unissued();
    ret = q.size() > 0 && q[0].done;
    full = q.size() == 16;
    hit = 0;
    if (mem_ready) begin
      foreach (q[k])
        if (q[k].id == mem_rid && q[k].issued && !q[k].rw && !q[k].done) begin
          q[k].done = 1; q[k].data = mem_rdata; hit = 1;
        end
      if (!hit) m_err = 1;
    end
    if (iss >= 0 && !mem_stall) begin
      q[iss].issued = 1;
      if (q[iss].rw) begin q[iss].done = 1; q[iss].data = 0; end
    end
    m_wbv = ret;
    if (ret) begin
      m_wba = q[0].addr; m_wbd = q[0].data; m_wbc = q[0].cntrl; m_wbz = q[0].z;
      void'(q.pop_front());
    end
    if (ex_valid && !full) begin
      r.id = 4'(next_id); r.rw = ex_rw; r.addr = ex_addr; r.data = ex_wdata;
      r.cntrl = ex_cntrl; r.z = ex_z; r.issued = 0; r.done = 0;
      q.push_back(r);
      next_id = (next_id + 1) % 16;
    end
  endtask

  task automatic model_compare();
    int iss;
    iss = first_unissued();
    check("mem_valid", mem_valid, iss >= 0);
    if (iss >= 0) begin
      check("mem_id", mem_id, q[iss].id);
      check("mem_rw", mem_rw, q[iss].rw);
      check("mem_addr", mem_addr, q[iss].addr);
      check("mem_data", mem_data, q[iss].data);
    end
    check("stall_out", stall_out, q.size() == 16);
    check("wb_valid", wb_valid, m_wbv);
    check("wb_addr", wb_addr, m_wba);
    check("wb_data", wb_data, m_wbd);
    check("wb_cntrl", wb_cntrl, m_wbc);
    check("wb_z", wb_z, m_wbz);
    check("err_out", err_out, m_err);
  endtask

  task automatic settle();
    if (rst) model_reset();
    #2;
    model_compare();
  endtask

  task automatic edge_();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic cyc();
    settle();
    edge_();
  endtask

  task automatic idle();
    rst = 0; ex_valid = 0; mem_ready = 0; mem_stall = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  typedef struct {
    bit rst, ev, rw;
    logic [31:0] addr, wdata;
    bit ms, mr;
    logic [3:0] rid;
    logic [31:0] rdata;
    bit e_mv;
    logic [3:0] e_mid;
    bit e_rw;
    logic [31:0] e_maddr;
    bit e_stall, e_wbv;
    logic [31:0] e_wba, e_wbd;
    bit e_err;
  } vec_t;
  vec_t vt [15];

  initial begin
    // rst ev rw addr wdata ms mr rid rdata | mv mid rw maddr stall wbv wba wbd err
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 0, 1, 32'h40, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 1, 32'h40, 0, 0};
    vt[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 1, 0, 32'h10, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 1, 0, 32'h14, 0, 0, 0, 0, 0,         1, 0, 0, 32'h10, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 1, 0, 32'h14, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 32'h22,         0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 32'h11,         0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 1, 32'h10, 32'h11, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 1, 32'h14, 32'h22, 0};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 0};
    #1;
    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; ex_valid = vt[i].ev; ex_rw = vt[i].rw; ex_addr = vt[i].addr;
      ex_wdata = vt[i].wdata; mem_stall = vt[i].ms; mem_ready = vt[i].mr;
      mem_rid = vt[i].rid; mem_rdata = vt[i].rdata; ex_cntrl = 16'(i); ex_z = 4'(i);
      settle();
      check($sformatf("vec%0d_mem_valid", i), mem_valid, vt[i].e_mv);
      if (vt[i].e_mv) begin
        check($sformatf("vec%0d_mem_id", i), mem_id, vt[i].e_mid);
        check($sformatf("vec%0d_mem_rw", i), mem_rw, vt[i].e_rw);
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].e_maddr);
      end
      check($sformatf("vec%0d_stall", i), stall_out, vt[i].e_stall);
      check($sformatf("vec%0d_wb_valid", i), wb_valid, vt[i].e_wbv);
      if (vt[i].e_wbv) begin
        check($sformatf("vec%0d_wb_addr", i), wb_addr, vt[i].e_wba);
        check($sformatf("vec%0d_wb_data", i), wb_data, vt[i].e_wbd);
      end
      check($sformatf("vec%0d_err", i), err_out, vt[i].e_err);
      edge_();
    end

    // Fill all 16 ids, hold a 17th request, free id 0 and watch the wrap
    do_reset();
    ex_rw = 0;
    for (int i = 0; i < 16; i++) begin
      ex_valid = 1; ex_addr = 32'h100 + 32'(4 * i);
      cyc();
    end
    ex_addr = 32'h999;
    settle(); check("full_stall", stall_out, 1); edge_();
    mem_ready = 1; mem_rid = 0; mem_rdata = 32'hAA;
    settle(); check("full_no_17th", mem_valid, 0); edge_();
    mem_ready = 0;
    settle(); check("full_stall_hold", stall_out, 1); edge_();
    settle(); check("full_stall_drop", stall_out, 0); check("full_wb_data", wb_data, 32'hAA); edge_();
    ex_valid = 0;
    settle(); check("wrap_valid", mem_valid, 1); check("wrap_id", mem_id, 0);
    check("wrap_addr", mem_addr, 32'h999); edge_();

    // Memory stall holding two queued loads
    do_reset();
    ex_valid = 1; ex_rw = 0; ex_addr = 32'h200; cyc();
    ex_addr = 32'h204; mem_stall = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("mstall_valid", mem_valid, 1); check("mstall_id", mem_id, 0);
      check("mstall_addr", mem_addr, 32'h200);
      edge_();
      ex_valid = 0;
    end
    mem_stall = 0;
    settle(); check("mstall_rel_id0", mem_id, 0); edge_();
    settle(); check("mstall_rel_id1", mem_id, 1); check("mstall_rel_addr1", mem_addr, 32'h204); edge_();
    settle(); check("mstall_drained", mem_valid, 0); edge_();

    // Response to a FREE id; a later store must flow normally
    do_reset();
    mem_ready = 1; mem_rid = 7; mem_rdata = 32'h5;
    settle(); check("err_before", err_out, 0); edge_();
    mem_ready = 0;
    settle(); check("err_set", err_out, 1); check("err_no_wb", wb_valid, 0); edge_();
    ex_valid = 1; ex_rw = 1; ex_addr = 32'h80; ex_wdata = 32'h1234; cyc();
    ex_valid = 0; cyc(); cyc();
    settle(); check("err_store_wb", wb_valid, 1); check("err_store_addr", wb_addr, 32'h80);
    check("err_sticky", err_out, 1); edge_();

    // Asynchronous reset with three loads pending and one waiting
    do_reset();
    ex_rw = 0;
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; ex_addr = 32'h300 + 32'(4 * i);
      cyc();
    end
    ex_valid = 0; mem_stall = 1;
    settle(); check("pre_rst_valid", mem_valid, 1); check("pre_rst_id", mem_id, 3);
    #1 rst = 1;
    settle(); check("rst_mem_valid", mem_valid, 0); check("rst_stall", stall_out, 0);
    check("rst_wb_valid", wb_valid, 0); check("rst_err", err_out, 0);
    edge_();
    rst = 0; mem_stall = 0;
    mem_ready = 1; mem_rid = 1; mem_rdata = 32'hFF; ex_valid = 1; ex_addr = 32'h400;
    cyc();
    mem_ready = 0; ex_valid = 0;
    settle(); check("post_rst_err", err_out, 1); check("post_rst_id", mem_id, 0);
    check("post_rst_valid", mem_valid, 1); edge_();

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ids[$];
      ex_valid = $urandom_range(0, 1);
      ex_rw = $urandom_range(0, 1);
      ex_addr = $urandom; ex_wdata = $urandom;
      ex_cntrl = 16'($urandom); ex_z = 4'($urandom);
      mem_stall = $urandom_range(0, 3) == 0;
      foreach (q[k]) if (q[k].issued && !q[k].rw && !q[k].done) ids.push_back(q[k].id);
      mem_ready = ids.size() > 0 && $urandom_range(0, 9) < 4;
      mem_rid = mem_ready ? ids[$urandom_range(0, ids.size() - 1)] : 4'($urandom);
      mem_rdata = $urandom;
      cyc();
    end
    idle();
    for (int i = 0; i < 40; i++) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_tracker.md
Name: mem_req_tracker

Overview:
- Sits between the EX/MEM pipeline register and memory_system.
- Allocates a 4-bit ld/st id per request and issues requests to memory in program order, honouring the memory stall.
- Collects possibly out-of-order responses by id and retires results in program order to the MEM/WB register.
- Raises the pipeline stall when all ids are in flight.

Parameters:
DEPTH, 16, tracker entries; equals id space, must be 2^ID_W
ID_W, 4, id width
ADDR_W, 32, address width
DATA_W, 32, data width
CNTRL_W, 16, cntrl (m/w) bundle width
Z_W, 4, Z (dest reg) width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ex_valid  in  1  EX/MEM has a memory op this cycle
ex_rw  in  1  1=store, 0=load
ex_addr  in  ADDR_W  alu_out (address)
ex_wdata  in  DATA_W  store data
ex_cntrl  in  CNTRL_W  control bundle carried to WB
ex_z  in  Z_W  destination register
stall_out  out  1  pipeline must hold; tracker full
mem_valid  out  1  request valid to memory_system
mem_rw  out  1  request r/w
mem_addr  out  ADDR_W  request address
mem_data  out  DATA_W  request store data
mem_id  out  ID_W  request id
mem_stall  in  1  memory_system cannot accept
mem_rdata  in  DATA_W  response data
mem_rid  in  ID_W  response id
mem_ready  in  1  response valid
wb_valid  out  1  retired op valid (one cycle)
wb_addr  out  ADDR_W  retired alu_out
wb_data  out  DATA_W  load data; 0 for stores
wb_cntrl  out  CNTRL_W  retired cntrl
wb_z  out  Z_W  retired Z
err_out  out  1  sticky: response to a non-PENDING id

Behaviour:
- State: circular buffer of DEPTH entries. Pointers alloc_ptr, issue_ptr and retire_ptr are ID_W bits and wrap naturally. count is ID_W+1 bits.
- Entry id = entry index.
- Entry states: FREE -> WAIT (allocated) -> PENDING (issued load) -> DONE -> FREE.
- Reset (async, any time, including mid-operation):
  - All entries FREE; pointers and count 0.
  - All outputs 0, including err_out.
  - In-flight responses after reset release are ignored and flagged by err_out.
- Allocate:
  - stall_out = (count == DEPTH), decoded from registered count.
  - On ex_valid && !stall_out: write entry[alloc_ptr] with WAIT, payload; alloc_ptr++.
  - ex_valid while stall_out is dropped; the pipeline holds it.
- Issue:
  - mem_valid = entry[issue_ptr] is WAIT. mem_* are driven combinationally from that entry.
  - Handshake completes on mem_valid && !mem_stall at a clk edge: issue_ptr++.
  - Load -> PENDING. Store -> DONE, data 0.
  - Issue is strictly in order, at most 1 per cycle.
  - Earliest issue is the cycle after allocation.
- Response:
  - On mem_ready: if entry[mem_rid] is PENDING, capture mem_rdata and set DONE.
  - Otherwise ignore and set err_out.
  - A response in the same cycle as its own issue is impossible; it is treated as the non-PENDING case.
- Retire:
  - If entry[retire_ptr] is DONE: at the edge, register wb_* from the entry, set wb_valid=1, free the entry, retire_ptr++.
  - Otherwise wb_valid=0. wb_* hold their last values.
- count: +1 on allocate, -1 on retire. Both in the same edge leaves count unchanged.
- Full boundary: a retire in the full cycle does not allow a same-cycle allocate (stall_out is registered-count based). The allocate succeeds the next cycle.
- Latency, store with no stall: accepted at edge N, issued at edge N+1, wb_valid high after edge N+2.
- Latency, load: wb_valid high one edge after the response edge, provided it is oldest.

Decomposition:
- Package mem_pkg:
  - entry state enum (FREE, WAIT, PENDING, DONE)
  - ID_W/DEPTH/width constants
  - entry struct: state, rw, addr, data, cntrl, z
- Sub-module mem_req_slot (one entry register plus state transitions) is natural, instantiated DEPTH times.
- The pointer and count logic stays in the top.

Test Plan:
- Store, ex_addr=0x40, ex_wdata=0xDEADBEEF, no stall:
  - mem_valid at cycle 1 with mem_id=0, mem_rw=1.
  - wb_valid pulse at cycle 3 with wb_addr=0x40, wb_data=0.
- Loads to 0x10 (id 0) and 0x14 (id 1); responses arrive id1 (0x22) then id0 (0x11):
  - wb retires 0x11 first, then 0x22, in consecutive cycles.
- 16 loads with no responses:
  - stall_out=1 after the 16th accept.
  - A 17th ex_valid is not allocated.
  - Responding to id 0 makes stall_out drop the cycle after retire.
  - Next alloc id=0 (wrap).
- mem_stall held 5 cycles with 2 queued requests:
  - mem_valid/mem_addr stable throughout.
  - Issues resume in order after release.
- mem_ready with mem_rid=7 while entry 7 FREE:
  - err_out=1, sticky.
  - No wb_valid.
  - Other traffic unaffected.
- rst asserted mid-flight with 3 entries pending:
  - Immediately mem_valid=0, stall_out=0, wb_valid=0.
  - After release the first allocation gets id 0.
